// File: rtl/i2c_color_target.sv
// I2C target exposing a 32-byte TCS3472-style register file, with a local load port and bus-write strobe.
// Define I2C_TARGET_CMD_BIT_EN to treat the pointer byte as a TCS3472 command byte.
module i2c_color_target #(
  parameter logic [6:0] DEV_ADDR = 7'h29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic       ld_en,
  input  logic [4:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       wr_stb,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_PTR_ACK  = 4'd4;
  localparam logic [3:0] S_WR       = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD       = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;

  logic [1:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic             scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [3:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             ack_ph_q, ack_ph_d;
  logic             sda_oe_q, sda_oe_d;
  logic [4:0]       ptr_q, ptr_d;
  logic             auto_inc_q, auto_inc_d;
  logic             busy_q, busy_d;
  logic             wr_stb_q, wr_stb_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [31:0][7:0] regs_q, regs_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in, rd_byte;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign rd_byte   = regs_q[ptr_q];

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ack_ph_d   = ack_ph_q;
    sda_oe_d   = sda_oe_q;
    ptr_d      = ptr_q;
    auto_inc_d = auto_inc_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;
    // Local load first so a same-cycle bus write to the same index overrides it.
    if (ld_en) regs_d[ld_addr] = ld_data;

    if (stop_det) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd7;
      sda_oe_d  = 1'b0;
      ack_ph_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = byte_in;
          if (bit_cnt_q == 3'd0) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d  = S_ADDR_ACK;
              busy_d   = 1'b1;
              ack_ph_d = 1'b0;
            end else begin
              state_d  = S_IDLE;
              sda_oe_d = 1'b0;
            end
          end else bit_cnt_d = bit_cnt_q - 3'd1;
        end
        // Phase 0 waits for the 8th fall to pull ACK; phase 1 releases on the 9th fall.
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            sda_oe_d = 1'b1;
            ack_ph_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd7;
            if (state_q == S_ADDR_ACK && shift_q[0]) begin
              state_d  = S_RD;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else if (state_q == S_ADDR_ACK) state_d = S_PTR;
            else state_d = S_WR;
          end
        end
        S_PTR: if (scl_rise) begin
          shift_d = byte_in;
          if (bit_cnt_q == 3'd0) begin
`ifdef I2C_TARGET_CMD_BIT_EN
            if (!byte_in[7]) begin
              state_d  = S_IDLE;
              sda_oe_d = 1'b0;
            end else begin
              ptr_d      = byte_in[4:0];
              auto_inc_d = (byte_in[6:5] == 2'b01);
              state_d    = S_PTR_ACK;
              ack_ph_d   = 1'b0;
            end
`else
            ptr_d      = byte_in[4:0];
            auto_inc_d = 1'b1;
            state_d    = S_PTR_ACK;
            ack_ph_d   = 1'b0;
`endif
          end else bit_cnt_d = bit_cnt_q - 3'd1;
        end
        S_WR: if (scl_rise) begin
          shift_d = byte_in;
          if (bit_cnt_q == 3'd0) begin
            regs_d[ptr_q] = byte_in;
            wr_stb_d      = 1'b1;
            wr_addr_d     = ptr_q;
            wr_data_d     = byte_in;
            if (auto_inc_q) ptr_d = ptr_q + 5'd1;
            state_d  = S_WR_ACK;
            ack_ph_d = 1'b0;
          end else bit_cnt_d = bit_cnt_q - 3'd1;
        end
        S_RD: begin
          if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
          if (scl_rise) begin
            if (bit_cnt_q == 3'd0) begin
              state_d  = S_RD_ACK;
              ack_ph_d = 1'b0;
            end else bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        S_RD_ACK: begin
          if (!ack_ph_q) begin
            if (scl_fall) sda_oe_d = 1'b0;
            if (scl_rise) begin
              if (sda_s) state_d = S_IDLE;
              else begin
                ack_ph_d = 1'b1;
                if (auto_inc_q) ptr_d = ptr_q + 5'd1;
              end
            end
          end else if (scl_fall) begin
            ack_ph_d  = 1'b0;
            state_d   = S_RD;
            bit_cnt_d = 3'd7;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= '0;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      ptr_q      <= '0;
      auto_inc_q <= 1'b1;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      regs_q     <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ack_ph_q   <= ack_ph_d;
      sda_oe_q   <= sda_oe_d;
      ptr_q      <= ptr_d;
      auto_inc_q <= auto_inc_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_color_target.sv
// Scoreboard bench for i2c_color_target: a bit-banged master drives the bus, a monitor checks strobes, read bytes and status.
module tb_i2c_color_target;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  wire        sda;
  logic       wr_stb;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_color_target #(.DEV_ADDR(7'h29)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
  typedef struct { string name; int act; int exp; } chk_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] obs_rd[$];
  chk_t       chk_q[$];
  int checks = 0;
  int failures = 0;
  wr_t        mw;
  logic [7:0] mo, me;
  chk_t       mc;

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    if (rst && wr_stb) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_stb_unexpected: got addr=%h data=%h, required no strobe", wr_addr, wr_data);
      end else begin
        mw = exp_wr.pop_front();
        if (wr_addr !== mw.a || wr_data !== mw.d) begin
          failures++;
          $display("FAIL wr_stb: got addr=%h data=%h, required addr=%h data=%h", wr_addr, wr_data, mw.a, mw.d);
        end
      end
    end
    while (obs_rd.size() > 0) begin
      mo = obs_rd.pop_front();
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_byte_unexpected: got %h, required nothing", mo);
      end else begin
        me = exp_rd.pop_front();
        if (mo !== me) begin
          failures++;
          $display("FAIL rd_byte: got %h, required %h", mo, me);
        end
      end
    end
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      checks++;
      if (mc.act != mc.exp) begin
        failures++;
        $display("FAIL %s: got %0d, required %0d", mc.name, mc.act, mc.exp);
      end
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got no end of stimulus, required finish within budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input int a, input int e);
    chk_q.push_back('{n, a, e});
  endtask

  task automatic q();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; q(); scl = 1'b1; q(); m_sda_oe = 1'b1; q(); scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; q(); scl = 1'b1; q(); m_sda_oe = 1'b0; q(); q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_oe = 1'b0; q(); scl = 1'b1; q(); b = sda; q(); scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
    send_bit(nack);
  endtask

  function automatic logic [7:0] pb(input logic [4:0] p);
`ifdef I2C_TARGET_CMD_BIT_EN
    return {3'b101, p};
`else
    return {3'b000, p};
`endif
  endfunction

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic set_ptr(input logic [4:0] p, input string tag);
    logic a;
    i2c_start();
    write_byte(8'h52, a); chk({tag, "_addr_ack"}, a, 0);
    write_byte(pb(p), a); chk({tag, "_ptr_ack"}, a, 0);
  endtask

  task automatic rd_seq(input logic [4:0] p, input int n, input string tag);
    logic a;
    logic [7:0] b;
    set_ptr(p, tag);
    i2c_start();
    write_byte(8'h53, a); chk({tag, "_raddr_ack"}, a, 0);
    for (int k = 0; k < n; k++) begin
      read_byte(b, k == n - 1);
      obs_rd.push_back(b);
    end
    i2c_stop();
    chk({tag, "_busy_after_stop"}, busy, 0);
  endtask

  initial begin
    logic a;
    logic [7:0] b;
    repeat (5) @(negedge clk);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda_released", sda, 1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // load then pointer write, repeated START, single read
    load(5'h16, 8'hAB);
    set_ptr(5'h16, "ld_rd");
    chk("busy_in_txn", busy, 1);
    i2c_start();
    write_byte(8'h53, a); chk("ld_rd_raddr_ack", a, 0);
    exp_rd.push_back(8'hAB);
    read_byte(b, 1'b1); obs_rd.push_back(b);
    i2c_stop();
    chk("busy_after_stop", busy, 0);

    // two-byte bus write with strobes, then read back
    set_ptr(5'h10, "wr");
    exp_wr.push_back('{5'h10, 8'h5A});
    write_byte(8'h5A, a); chk("wr_d0_ack", a, 0);
    exp_wr.push_back('{5'h11, 8'h5B});
    write_byte(8'h5B, a); chk("wr_d1_ack", a, 0);
    i2c_stop();
    exp_rd.push_back(8'h5A); exp_rd.push_back(8'h5B);
    rd_seq(5'h10, 2, "wr_rb");

    // foreign address is ignored
    i2c_start();
    write_byte(8'h60, a); chk("bad_addr_nack", a, 1);
    chk("bad_addr_busy", busy, 0);
    i2c_stop();

    // burst read wrapping 0x1F -> 0x00
    load(5'h1F, 8'h11); load(5'h00, 8'h22); load(5'h01, 8'h33);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    rd_seq(5'h1F, 3, "wrap");

    // STOP after 4 data bits: no write
    load(5'h05, 8'h3C);
    set_ptr(5'h05, "part");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    chk("part_busy", busy, 0);
    exp_rd.push_back(8'h3C);
    rd_seq(5'h05, 1, "part_rb");

    // reset while the target drives a zero data bit
    set_ptr(5'h07, "rstrd");
    i2c_start();
    write_byte(8'h53, a); chk("rstrd_raddr_ack", a, 0);
    for (int i = 0; i < 3; i++) read_bit(a);
    chk("rstrd_driving_low", sda, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstrd_sda_released", sda, 1);
    chk("rstrd_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1; m_sda_oe = 1'b0; scl = 1'b1;
    q(); q();
    set_ptr(5'h03, "post_rst");
    exp_wr.push_back('{5'h03, 8'hC3});
    write_byte(8'hC3, a); chk("post_rst_d_ack", a, 0);
    i2c_stop();
    exp_rd.push_back(8'hC3); exp_rd.push_back(8'h00);
    rd_seq(5'h03, 2, "post_rst_rb");

`ifdef I2C_TARGET_CMD_BIT_EN
    load(5'h16, 8'hAB);
    i2c_start();
    write_byte(8'h52, a); chk("cmd_addr_ack", a, 0);
    write_byte(8'h16, a); chk("cmd_bit7_nack", a, 1);
    i2c_stop();
    i2c_start();
    write_byte(8'h52, a); chk("cmd_fix_addr_ack", a, 0);
    write_byte(8'h96, a); chk("cmd_fix_ptr_ack", a, 0);
    i2c_start();
    write_byte(8'h53, a); chk("cmd_fix_raddr_ack", a, 0);
    exp_rd.push_back(8'hAB); exp_rd.push_back(8'hAB);
    read_byte(b, 1'b0); obs_rd.push_back(b);
    read_byte(b, 1'b1); obs_rd.push_back(b);
    i2c_stop();
`endif

    repeat (40) @(negedge clk);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_color_target.md
# i2c_color_target

I2C target (responder) that presents a 32-byte TCS3472-style register file on the two-wire bus, at the opposite end of the bus from the team's I2C master. Used as a synthesizable sensor model in benches, and as an FPGA-side register window that an external master can poll. Local logic loads sample values (clear/red/green/blue) through a load port. Bus writes are reported to local logic through a strobe.

## Interface
Parameters:
- `DEV_ADDR`, default 7'h29: 7-bit target address.

Ports:
- `clk`, input, 1: system clock; must be ≥ 16× SCL frequency.
- `rst`, input, 1: synchronous, active-low reset.
- `scl`, input, 1: bus clock (target never stretches).
- `sda`, inout, 1: open-drain; driven 1'b0 or 1'bz only.
- `ld_en`, input, 1: local load strobe.
- `ld_addr`, input, 5: local load register index.
- `ld_data`, input, 8: local load value.
- `wr_stb`, output, 1: one-cycle pulse on every bus-written data byte.
- `wr_addr`, output, 5: register written by the bus; valid with `wr_stb`.
- `wr_data`, output, 8: value written by the bus; valid with `wr_stb`.
- `busy`, output, 1: high from address match to STOP.

## Operation
- Inputs: `scl` and `sda` each pass through a 2-FF synchronizer, then an edge detector on the synced values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in any state.
- Bits are sampled on SCL rising edges. SDA is changed only after SCL falling edges.
- Bit order: MSB first. `bit_cnt` counts 7 down to 0.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
  - IDLE: on START, go to ADDR.
  - ADDR: shift in 8 bits.
    - Address match: ACK, set `busy`. R/W=0 → PTR; R/W=1 → RD.
    - Mismatch: release SDA, go to IDLE.
  - PTR: latch the byte as the pointer (see Configuration), ACK, go to WR.
  - WR: on the 8th bit, write `regs[ptr]`, pulse `wr_stb`, ACK, increment the pointer.
  - RD: on entry, latch `regs[ptr]` into the shift register. Drive each bit low or release. Then go to RD_ACK.
  - RD_ACK: sample the master ACK.
    - ACK (0): increment the pointer, return to RD.
    - NACK (1): go to IDLE (wait for STOP).
- Pointer increment wraps 5'h1F → 5'h00.
- Repeated START (START while `busy`): go to ADDR. The pointer is kept, so write-pointer-then-read works.
- STOP: go to IDLE, clear `busy`, release SDA. A partial byte is discarded with no write.
- Load collision: `ld_en` and a bus write to the same index in the same cycle → the bus write wins. Loads to other indices always take effect.
- Read data is latched at the byte start. A load during the byte affects only the next read.
- Reset mid-transfer: SDA is released on the next clock. The FSM goes to IDLE.

## Timing
- Reset values:
  - `sda` = z; `wr_stb` = 0; `wr_addr` = 0; `wr_data` = 0; `busy` = 0.
  - Pointer = 0; all 32 registers = 8'h00.
- Edge detection latency: 3 `clk` cycles from a pad transition (2 synchronizer cycles plus 1 edge-detect cycle).
- SDA output update: 1 `clk` cycle after a detected SCL fall.
  - ACK drive begins after the 8th SCL fall and releases after the 9th SCL fall.
- `wr_stb` rises 1 cycle after the 8th data-bit SCL rise is detected. `wr_data` is stable from that point until the next strobe.
- A register loaded via `ld_en` is readable from the next cycle.

## Configuration
- `I2C_TARGET_CMD_BIT_EN` defined:
  - The pointer byte is a TCS3472 command byte. Bit7 must be 1, otherwise the byte is NACKed and the FSM goes to IDLE.
  - Bits[6:5]: 01 = auto-increment; 00 = repeated access to the same register.
  - Bits[4:0] = pointer.
- Not defined:
  - Pointer = byte[4:0]; bits[7:5] are ignored.
  - Auto-increment is always enabled.

## Test plan
- Load 0x16 = 0xAB via `ld_en`. Master writes pointer 0x16, repeated START, reads 1 byte with NACK → `sda` returns 0xAB; all three ACKs are low.
- Master writes 0x10 then data 0x5A, 0x5B → `wr_stb` pulses twice: (0x10, 0x5A), then (0x11, 0x5B). A later read at 0x10 returns 0x5A, 0x5B.
- Address 0x30 → no ACK on the 9th SCL; `sda` stays z; `busy` stays 0; no `wr_stb`.
- Pointer 0x1F, 3-byte burst read with regs 0x1F = 0x11, 0x00 = 0x22, 0x01 = 0x33 → 0x11, 0x22, 0x33 (wrap-around).
- STOP after 4 data bits of a write → no `wr_stb`; register unchanged; `busy` = 0.
  - Separately: assert `rst` = 0 mid-read → `sda` = z within 1 cycle; a new transaction succeeds.
- With `I2C_TARGET_CMD_BIT_EN`:
  - Pointer byte 0x16 → NACK.
  - Pointer byte 0x96 (bit7 = 1, no auto-increment), 2-byte read → 0xAB, 0xAB.
